// File: rtl/raiz_pkg.sv
// Shared register map, CTRL/STATUS bit positions and engine state encoding
// for the square-root peripheral.
package raiz_pkg;
   localparam int OFF_OPA    = 'h04;
   localparam int OFF_CTRL   = 'h08;
   localparam int OFF_RESULT = 'h0C;
   localparam int OFF_STATUS = 'h10;
   localparam int OFF_REM    = 'h14;

   localparam int CTRL_START   = 0;
   localparam int CTRL_IEN     = 1;
   localparam int CTRL_CLR_OVR = 2;

   localparam int ST_DONE = 0;
   localparam int ST_BUSY = 1;
   localparam int ST_OVR  = 2;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_CALC = 1'b1
   } raiz_state_t;
endpackage

// File: rtl/raiz_iter.sv
// Iterative restoring square root: one root bit per CALC cycle, DATA_W/2 cycles.
// root/rem carry the final values only in the cycle done_pulse is high.
module raiz_iter
   import raiz_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] op,
   output logic              busy,
   output logic              done_pulse,
   output logic [DATA_W/2-1:0] root,
   output logic [DATA_W/2:0]   rem
);
   localparam int N  = DATA_W / 2;
   localparam int CW = $clog2(N);

   raiz_state_t state_q, state_d;
   logic [CW-1:0]     cnt_q;
   logic [DATA_W-1:0] op_q;
   logic [N-1:0]      root_q;
   logic [N:0]        rem_q;
   logic [N+2:0]      rem_sh, trial;
   logic [N:0]        diff;
   logic              ge;
   logic              last;

   // Bring down the next operand pair and try subtracting 4*root+1.
   always_comb begin
      rem_sh = {rem_q, op_q[DATA_W-1 -: 2]};
      trial  = {1'b0, root_q, 2'b01};
      ge     = (rem_sh >= trial);
      diff   = rem_sh[N:0] - trial[N:0];
      root   = {root_q[N-2:0], ge};
      rem    = ge ? diff : rem_sh[N:0];
      last   = (cnt_q == CW'(N - 1));
   end

   always_ff @(posedge CLK) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      busy       = (state_q == S_CALC);
      done_pulse = 1'b0;
      case (state_q)
         S_IDLE: if (start) state_d = S_CALC;
         S_CALC: begin
            if (last) begin
               state_d    = S_IDLE;
               done_pulse = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         cnt_q  <= '0;
         op_q   <= '0;
         root_q <= '0;
         rem_q  <= '0;
      end else if (state_q == S_IDLE && start) begin
         cnt_q  <= '0;
         op_q   <= op;
         root_q <= '0;
         rem_q  <= '0;
      end else if (state_q == S_CALC) begin
         cnt_q  <= cnt_q + 1'b1;
         op_q   <= op_q << 2;
         root_q <= root;
         rem_q  <= rem;
      end
   end
endmodule

// File: rtl/periferico_raiz_n.sv
// Bus-mapped square-root peripheral: register decode, sticky status bits and
// the level interrupt around the raiz_iter engine.
module periferico_raiz_n
   import raiz_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic [DATA_W-1:0] d_in,
   input  logic              cs,
   input  logic [ADDR_W-1:0] addr,
   input  logic              rd,
   input  logic              wr,
   output logic [DATA_W-1:0] d_out,
   output logic              irq
);
   localparam int N = DATA_W / 2;

   // Bus: rd/wr are single-cycle strobes qualified by cs on the same rising
   // edge; there is no ready/wait, every qualified access completes that edge
   // and read data appears on d_out after it.
   logic [DATA_W-1:0] op_a_q;
   logic              ien_q, done_q, ovr_q;
   logic [N-1:0]      result_q;
   logic [N:0]        remain_q;
   logic              busy, done_pulse;
   logic [N-1:0]      eng_root;
   logic [N:0]        eng_rem;
   logic              wr_acc, rd_acc, ctrl_wr, start_req, start_ok, start_ovr;
   logic [DATA_W-1:0] rd_data;

   raiz_iter #(.DATA_W(DATA_W)) u_iter (
      .CLK        (CLK),
      .reset      (reset),
      .start      (start_ok),
      .op         (op_a_q),
      .busy       (busy),
      .done_pulse (done_pulse),
      .root       (eng_root),
      .rem        (eng_rem)
   );

   always_comb begin
      wr_acc    = cs & wr;
      rd_acc    = cs & rd;
      ctrl_wr   = wr_acc & (addr == ADDR_W'(OFF_CTRL));
      start_req = ctrl_wr & d_in[CTRL_START];
      start_ok  = start_req & ~busy;
      start_ovr = start_req & busy;
   end

   always_comb begin
      rd_data = '0;
      case (addr)
         ADDR_W'(OFF_OPA):    rd_data = op_a_q;
         ADDR_W'(OFF_RESULT): rd_data = DATA_W'(result_q);
         ADDR_W'(OFF_REM):    rd_data = DATA_W'(remain_q);
         ADDR_W'(OFF_STATUS): begin
            rd_data[ST_DONE] = done_q;
            rd_data[ST_BUSY] = busy;
            rd_data[ST_OVR]  = ovr_q;
         end
         default: rd_data = '0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         op_a_q   <= '0;
         ien_q    <= 1'b0;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
         result_q <= '0;
         remain_q <= '0;
         d_out    <= '0;
      end else begin
         if (wr_acc && addr == ADDR_W'(OFF_OPA)) op_a_q <= d_in;
         if (ctrl_wr) ien_q <= d_in[CTRL_IEN];
         if (start_ok)        done_q <= 1'b0;
         else if (done_pulse) done_q <= 1'b1;
         // A rejected START on the same edge as CLR_OVR leaves OVR set.
         if (start_ovr)                          ovr_q <= 1'b1;
         else if (ctrl_wr && d_in[CTRL_CLR_OVR]) ovr_q <= 1'b0;
         if (done_pulse) begin
            result_q <= eng_root;
            remain_q <= eng_rem;
         end
         if (rd_acc) d_out <= rd_data;
      end
   end

   assign irq = done_q & ien_q;
endmodule

// File: doc/periferico_raiz_n.md
PERIFERICO_RAIZ_N -- requirements
Module: periferico_raiz_n

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning bus/operand width; must be even and >= 4.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning bus address width.
REQ-003 SHALL have port CLK  input  1  the single system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port d_in  input  DATA_W  write data from bus.
REQ-006 SHALL have port cs  input  1  chip select.
REQ-007 SHALL have port addr  input  ADDR_W  register offset.
REQ-008 SHALL have port rd  input  1  read strobe.
REQ-009 SHALL have port wr  input  1  write strobe.
REQ-010 SHALL have port d_out  output  DATA_W  registered read data.
REQ-011 SHALL have port irq  output  1  level interrupt, equal to DONE AND IEN.

Function
REQ-012 SHALL decode the map: 0x04 OP_A (RW), 0x08 CTRL (W: bit0 START, bit1 IEN, bit2 CLR_OVR), 0x0C RESULT (R), 0x10 STATUS (R: bit0 DONE, bit1 BUSY, bit2 OVR), 0x14 REMAINDER (R); other offsets read 0, ignore writes.
REQ-013 SHALL act on a register only when cs=1 on that edge; rd and wr are single-cycle strobes.
REQ-014 SHALL update d_out one edge after an accepted read; it holds its value when no read is accepted, and reads 0 for unmapped offsets.
REQ-015 SHALL treat START as a self-clearing pulse: a write with bit0=1 in IDLE loads OP_A into the engine and enters CALC on that edge; no software clear is needed.
REQ-016 SHALL implement engine states IDLE and CALC: CALC runs exactly DATA_W/2 cycles of restoring digit-by-digit square root (one result bit per cycle), then returns to IDLE.
REQ-017 SHALL fix latency: START accepted at edge t means BUSY=1 after edges t..t+DATA_W/2-1, and RESULT, REMAINDER and DONE=1 are valid after edge t+DATA_W/2.
REQ-018 SHALL produce RESULT = floor(sqrt(OP_A)), DATA_W/2 bits zero-extended, and REMAINDER = OP_A - RESULT^2, DATA_W/2+1 bits zero-extended; all unsigned.
REQ-019 SHALL hold DONE sticky until the next accepted START, which clears it on the same edge that enters CALC.
REQ-020 SHALL ignore START while BUSY, set sticky OVR, and leave the running computation undisturbed.
REQ-021 SHALL ignore OP_A writes during BUSY for the running computation, since the engine uses its loaded copy; the OP_A register itself updates.
REQ-022 SHALL clear OVR on a CTRL write with bit2=1; if the same edge also sets OVR, the set wins.
REQ-023 SHALL store IEN from CTRL bit1 on every CTRL write.
REQ-024 SHALL keep RESULT and REMAINDER at their previous values while CALC runs.

Reset
REQ-025 SHALL, on reset=1 at an edge, clear OP_A, IEN, DONE, OVR, RESULT, REMAINDER and d_out to 0, force the engine to IDLE, and drive irq=0.
REQ-026 SHALL abort a computation on reset mid-CALC; no DONE is produced afterwards.

Structure
REQ-027 SHALL place register offsets, CTRL/STATUS bit indices and the state encoding in shared package raiz_pkg.
REQ-028 SHALL place the iterative engine in sub-module raiz_iter, with ports CLK, reset, start, op (DATA_W), busy, done_pulse, root, rem; the bus decode and status registers stay in the top module.

Verification
REQ-029 SHALL verify: OP_A=144, START -> after 8 edges STATUS=0x1, RESULT=12, REMAINDER=0.
REQ-030 SHALL verify: OP_A=0xFFFF -> RESULT=255, REMAINDER=510; OP_A=0 -> RESULT=0, REMAINDER=0, DONE set after 8 edges.
REQ-031 SHALL verify: START again at cycle 3 of CALC with OP_A=144 -> STATUS=0x6 during CALC, first result still 12, OVR stays until a CTRL write of 0x4.
REQ-032 SHALL verify: IEN=1, OP_A=99 -> irq rises with DONE, RESULT=9, REMAINDER=18; irq falls on the next START.
REQ-033 SHALL verify: reset at cycle 4 of CALC -> STATUS=0, RESULT=0, irq=0, and DONE stays 0 for 20 cycles.
REQ-034 SHALL verify: DATA_W=32, OP_A=0xFFFFFFFF -> after 16 edges RESULT=65535, REMAINDER=131070; cs=0 during rd/wr causes no state change.
